pair_filter: RTL and testbench
==============================

Name: pair_filter

Overview:
- Upstream neighbour of the pair queue stage.
- Takes one reference particle and 14 neighbour-cell candidate particles per bundle, computes squared distance per lane in a pipeline, and marks out-of-cutoff or empty lanes invalid.
- Presents the 14-lane 194-bit pair bundle stable for a full 16-cycle frame, which is the rate at which the pair queue serialises its 14 inputs.

Parameters:
- NSIZE, 14, number of neighbour lanes.
- POS_W, 32, signed two's-complement fixed-point width per coordinate.
- PAIR_W, 194, width of one pair record.
- FRAME_LEN, 16, cycles each output bundle is held.
- CUTOFF_SQ, 68'd100, inclusive squared cutoff radius, same fixed-point scale squared.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ref_pos  in  96  reference particle {z,y,x}, 32 bits each.
- nbr_pos  in  96*NSIZE  lane i at [96*i +: 96], {z,y,x}.
- nbr_valid  in  NSIZE  lane i holds a real particle.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted on edge where in_valid&in_ready.
- out  out  PAIR_W*NSIZE  lane i at [194*i +: 194].
- frame_start  out  1  high for first cycle of each held frame.
- busy  out  1  high in COMPUTE or HOLD.

Behaviour:
- Pair record fields:
  - [95:0] ref_pos; [191:96] nbr_pos; [192] reserved, always 0.
  - [193] invalid: 1 means reject or empty slot.
- Reset asserted (async):
  - state=IDLE, fcnt=0, pipeline cleared.
  - out = every lane with bit193=1 and all other bits 0.
  - frame_start=0, busy=0, in_ready=0.
  - After release, in_ready=1 from the first cycle.
- States:
  - IDLE: in_ready=1. Accept → COMPUTE.
  - COMPUTE: 2 cycles, in_ready=0. The second edge loads out, sets fcnt=0 → HOLD.
  - HOLD: fcnt counts 0..FRAME_LEN-1, and out is held constant.
    - in_ready=1 only when fcnt==FRAME_LEN-3 and HOLD entry was not from reset.
    - Accept there: the edge ending fcnt=FRAME_LEN-1 loads the new bundle and sets fcnt=0; stay in HOLD with no gap.
    - No accept: at the end of fcnt=FRAME_LEN-1, out becomes all-invalid → IDLE.
- Latency: the accept edge captures s1 and the next edge captures s2. The third edge loads out; out is valid and frame_start=1 in the following cycle.
- Pipeline per lane:
  - s1: dx,dy,dz = nbr - ref, sign-extended to 33 bits (no wrap).
  - s2: squares, 66-bit unsigned.
  - Load: r2 = sum, 68 bits.
  - invalid = !nbr_valid_d | (r2 > CUTOFF_SQ) | (r2 == 0). r2==0 is self-pair exclusion.
  - ref/nbr positions and nbr_valid are delayed alongside the arithmetic.
- frame_start = (state==HOLD && fcnt==0).
- in_valid while in_ready=0 is ignored; the source must hold it.
- Reset mid-COMPUTE or mid-HOLD: in-flight and held bundles are discarded and out goes all-invalid immediately.

Decomposition:
- Package md_pair_pkg holds:
  - NSIZE, POS_W, PAIR_W, FRAME_LEN.
  - Field offsets REF_LSB=0, NBR_LSB=96, RSVD_BIT=192, INVALID_BIT=193.
  - State encoding IDLE/COMPUTE/HOLD.
- Sub-module pair_filter_lane (one per lane, generate loop) contains the s1/s2 registers, the r2 sum and compare, and the delayed payload.
- Top level owns the FSM, fcnt, in_ready and the out register.

Test Plan:
- Reset then release → out all 14 lanes bit193=1 and the rest zero; in_ready=1; frame_start=0; busy=0.
- ref=(0,0,0); lane0 (3,4,0), lane1 (10,0,0), lane2 (10,0,1), all other nbr_valid=0; CUTOFF_SQ=100:
  - out appears 3 edges after accept.
  - lane0 and lane1 bit193=0, lane2 and the rest bit193=1.
  - Bundle is stable 16 cycles, then all-invalid and IDLE.
- lane0 nbr equal to ref (5,5,5) with nbr_valid=1 → lane0 bit193=1 (self-pair).
- ref x=32'h7FFFFFFF, lane0 x=32'h80000000, y=z=0 → lane0 bit193=1 (no 32-bit wrap yields small r2).
- in_valid held high with 4 distinct bundles:
  - in_ready pulses once per 16 cycles at fcnt=13.
  - frame_start every 16 cycles with no idle gap.
  - Bundles appear in order.
- Assert reset at fcnt=7 of HOLD → out all-invalid and busy=0 immediately. After release, a new bundle completes normally.

Source files
------------

// File: rtl/md_pair_pkg.sv
// Shared constants, pair-record layout and FSM encoding for the pair filter.
package md_pair_pkg;

    localparam int NSIZE     = 14;               // neighbour lanes per bundle
    localparam int POS_W     = 32;               // signed fixed-point coordinate width
    localparam int VEC_W     = 3 * POS_W;        // {z,y,x}
    localparam int PAIR_W    = 194;              // one pair record
    localparam int FRAME_LEN = 16;               // cycles each bundle is held
    localparam int CNT_W     = $clog2(FRAME_LEN);

    localparam int DIFF_W = POS_W + 1;           // per-axis difference, no wrap
    localparam int SQ_W   = 2 * DIFF_W;          // per-axis square
    localparam int R2_W   = SQ_W + 2;            // sum of three squares

    // Pair record field offsets
    localparam int REF_LSB     = 0;
    localparam int NBR_LSB     = 96;
    localparam int RSVD_BIT    = 192;
    localparam int INVALID_BIT = 193;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Bundle with every lane marked invalid and all payload bits zero.
    function automatic logic [PAIR_W*NSIZE-1:0] all_invalid_bundle();
        logic [PAIR_W*NSIZE-1:0] v;
        v = '0;
        for (int i = 0; i < NSIZE; i++) begin
            v[i*PAIR_W + INVALID_BIT] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pair_filter_lane.sv
// One neighbour lane: per-axis difference (s1), squares (s2), then the r2 sum
// and cutoff/self-pair test feeding a complete pair record.
module pair_filter_lane
    import md_pair_pkg::*;
#(
    parameter logic [R2_W-1:0] CUTOFF_SQ = 68'd100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_s1_en,
    input  logic              i_s2_en,
    input  logic [VEC_W-1:0]  i_ref,
    input  logic [VEC_W-1:0]  i_nbr,
    input  logic              i_nbr_valid,
    output logic [PAIR_W-1:0] o_pair
);

    logic [SQ_W-1:0]  w_sq [3];
    logic [R2_W-1:0]  w_r2;
    logic             w_invalid;

    logic [VEC_W-1:0] r_ref_s1, r_nbr_s1, r_ref_s2, r_nbr_s2;
    logic             r_val_s1, r_val_s2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_axis
            logic [POS_W-1:0]  w_r;
            logic [POS_W-1:0]  w_n;
            logic [DIFF_W-1:0] r_d;
            logic [SQ_W-1:0]   w_dext;
            logic [SQ_W-1:0]   r_sq;

            assign w_r = i_ref[gi*POS_W +: POS_W];
            assign w_n = i_nbr[gi*POS_W +: POS_W];

            // s1: sign-extended difference so extreme coordinates cannot wrap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d <= '0;
                end else if (i_s1_en) begin
                    r_d <= {w_n[POS_W-1], w_n} - {w_r[POS_W-1], w_r};
                end
            end

            // Low SQ_W bits of the product of sign-extended operands are the exact square
            assign w_dext = {{(SQ_W-DIFF_W){r_d[DIFF_W-1]}}, r_d};

            // s2: per-axis square
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sq <= '0;
                end else if (i_s2_en) begin
                    r_sq <= w_dext * w_dext;
                end
            end

            assign w_sq[gi] = r_sq;
        end
    endgenerate

    // Payload and valid flag travel alongside the arithmetic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_s1 <= '0;
            r_nbr_s1 <= '0;
            r_val_s1 <= 1'b0;
            r_ref_s2 <= '0;
            r_nbr_s2 <= '0;
            r_val_s2 <= 1'b0;
        end else begin
            if (i_s1_en) begin
                r_ref_s1 <= i_ref;
                r_nbr_s1 <= i_nbr;
                r_val_s1 <= i_nbr_valid;
            end
            if (i_s2_en) begin
                r_ref_s2 <= r_ref_s1;
                r_nbr_s2 <= r_nbr_s1;
                r_val_s2 <= r_val_s1;
            end
        end
    end

    // r2 == 0 excludes the reference pairing with itself
    assign w_r2 = {2'b00, w_sq[0]} + {2'b00, w_sq[1]} + {2'b00, w_sq[2]};
    assign w_invalid = !r_val_s2 || (w_r2 > CUTOFF_SQ) || (w_r2 == '0);

    assign o_pair = {w_invalid, 1'b0, r_nbr_s2, r_ref_s2};

endmodule

// File: rtl/pair_filter.sv
// Pair filter top: accepts a reference plus NSIZE candidates, filters them by
// squared distance and holds the resulting bundle for FRAME_LEN cycles.
module pair_filter
    import md_pair_pkg::*;
#(
    parameter logic [R2_W-1:0] CUTOFF_SQ = 68'd100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [VEC_W-1:0]         ref_pos,
    input  logic [VEC_W*NSIZE-1:0]   nbr_pos,
    input  logic [NSIZE-1:0]         nbr_valid,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [PAIR_W*NSIZE-1:0]  out,
    output logic                     frame_start,
    output logic                     busy
);

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_fcnt, w_fcnt_next;
    logic               r_v1, r_v2;       // bundle present in s1 / s2
    logic               r_live;           // first clock after reset has passed
    logic               r_hold_ok;        // HOLD was entered by a real load
    logic               w_accept;
    logic               w_out_clear;
    logic [PAIR_W*NSIZE-1:0] w_pairs;

    assign w_accept = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NSIZE; gi++) begin : g_lane
            pair_filter_lane #(
                .CUTOFF_SQ (CUTOFF_SQ)
            ) u_lane (
                .clk         (clk),
                .rst_n       (reset),
                .i_s1_en     (w_accept),
                .i_s2_en     (r_v1),
                .i_ref       (ref_pos),
                .i_nbr       (nbr_pos[gi*VEC_W +: VEC_W]),
                .i_nbr_valid (nbr_valid[gi]),
                .o_pair      (w_pairs[gi*PAIR_W +: PAIR_W])
            );
        end
    endgenerate

    // State, frame counter and pipeline-occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_fcnt    <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_live    <= 1'b0;
            r_hold_ok <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fcnt  <= w_fcnt_next;
            r_v1    <= w_accept;
            r_v2    <= r_v1;
            r_live  <= 1'b1;
            if (r_v2) begin
                r_hold_ok <= 1'b1;
            end
        end
    end

    // Next state: a load (r_v2) always restarts the frame, otherwise the frame runs out
    always_comb begin
        w_state_next = r_state;
        w_fcnt_next  = r_fcnt;
        w_out_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_v2) begin
                    w_state_next = HOLD;
                    w_fcnt_next  = '0;
                end
            end
            HOLD: begin
                if (r_v2) begin
                    w_fcnt_next = '0;
                end else if (r_fcnt == CNT_W'(FRAME_LEN-1)) begin
                    w_state_next = IDLE;
                    w_fcnt_next  = '0;
                    w_out_clear  = 1'b1;
                end else begin
                    w_fcnt_next = r_fcnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_fcnt_next  = '0;
            end
        endcase
    end

    // Output bundle register, all-invalid whenever nothing is being presented
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= all_invalid_bundle();
        end else if (r_v2) begin
            out <= w_pairs;
        end else if (w_out_clear) begin
            out <= all_invalid_bundle();
        end
    end

    // Accepting at fcnt == FRAME_LEN-3 lands the next load exactly on the frame boundary
    always_comb begin
        in_ready = 1'b0;
        if (r_live) begin
            if (r_state == IDLE) begin
                in_ready = 1'b1;
            end else if (r_state == HOLD && r_hold_ok &&
                         r_fcnt == CNT_W'(FRAME_LEN-3)) begin
                in_ready = 1'b1;
            end
        end
    end

    assign frame_start = (r_state == HOLD) && (r_fcnt == '0);
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pair_filter.sv
// Scoreboard bench for pair_filter: the driver pushes hand-computed bundles and
// their expected arrival time, the monitor checks every presented frame.
module tb_pair_filter;
    import md_pair_pkg::*;

    localparam int BW = PAIR_W * NSIZE;
    localparam int NW = 96 * NSIZE;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [95:0]   ref_pos = '0;
    logic [NW-1:0] nbr_pos = '0;
    logic [13:0]   nbr_valid = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_bus;
    logic          frame_start;
    logic          busy;

    always #5 clk = ~clk;

    pair_filter dut (
        .clk         (clk),
        .reset       (reset),
        .ref_pos     (ref_pos),
        .nbr_pos     (nbr_pos),
        .nbr_valid   (nbr_valid),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out         (out_bus),
        .frame_start (frame_start),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] exp_q [$];
    time           tim_q [$];
    logic [BW-1:0] cur_exp;
    logic [BW-1:0] all_inv;
    int            age = -1;

    function automatic logic [95:0] v3(logic [31:0] x, logic [31:0] y, logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic logic [BW-1:0] mk_exp(logic [95:0] r, logic [NW-1:0] n, logic [13:0] inv);
        logic [BW-1:0] e;
        e = '0;
        for (int i = 0; i < NSIZE; i++) begin
            e[194*i +: 194] = {inv[i], 1'b0, n[96*i +: 96], r};
        end
        return e;
    endfunction

    task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic check_bundle(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        int lane;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            lane = 0;
            for (int i = NSIZE-1; i >= 0; i--) begin
                if (act[194*i +: 194] !== exp[194*i +: 194]) lane = i;
            end
            $display("FAIL %s lane %0d: got %h expected %h", name, lane,
                     act[194*lane +: 194], exp[194*lane +: 194]);
        end
    endtask

    // Monitor: pop on every frame start, then check hold stability and frame end
    always @(negedge clk) begin
        if (!reset) begin
            age = -1;
        end else if (frame_start) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got frame_start at %0t expected none", $time);
            end else begin
                time t_exp;
                cur_exp = exp_q.pop_front();
                t_exp   = tim_q.pop_front();
                check_val("frame_latency_time", 64'($time), 64'(t_exp));
                check_bundle("frame_out", out_bus, cur_exp);
                $display("[TB] frame at %0t invalid lanes checked", $time);
            end
            age = 0;
        end else if (age >= 0) begin
            age++;
            if (age < FRAME_LEN) begin
                check_bundle("hold_stable", out_bus, cur_exp);
            end else begin
                check_bundle("frame_end_invalid", out_bus, all_inv);
                check_val("frame_end_idle_busy", 64'(busy), 64'd0);
                age = -1;
            end
        end
    end

    // Offer a bundle (inputs set now, at a negedge) and wait for acceptance
    task automatic send(logic [95:0] r, logic [NW-1:0] n, logic [13:0] nv,
                        logic [13:0] inv, output time acc_t);
        bit found;
        ref_pos   = r;
        nbr_pos   = n;
        nbr_valid = nv;
        in_valid  = 1'b1;
        found     = 0;
        acc_t     = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (in_ready) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
        end else begin
            acc_t = $time;
            exp_q.push_back(mk_exp(r, n, inv));
            tim_q.push_back($time + 30);
            $display("[TB] accept at %0t ref=%h", $time, r);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        @(negedge clk);
    endtask

    logic [NW-1:0] nb;
    logic [13:0]   nv;
    time           t0, t1, t2, t3;

    initial begin
        all_inv = '0;
        for (int i = 0; i < NSIZE; i++) all_inv[194*i + 193] = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_bundle("reset_out", out_bus, all_inv);
        check_val("reset_in_ready", 64'(in_ready), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_frame_start", 64'(frame_start), 64'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("ready_after_reset", 64'(in_ready), 64'd1);

        // Basic cutoff: 25 in, 100 in (inclusive), 101 out, empty lanes out
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(3, 4, 0);  nv[0] = 1'b1;
        nb[96*1 +: 96] = v3(10, 0, 0); nv[1] = 1'b1;
        nb[96*2 +: 96] = v3(10, 0, 1); nv[2] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h3FFC, t0);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("compute_busy", 64'(busy), 64'd1);
        check_val("compute_not_ready", 64'(in_ready), 64'd0);
        wait_idle();

        // Self pair, negative delta, r2 = 1
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(5, 5, 5);            nv[0] = 1'b1;
        nb[96*1 +: 96] = v3(5, 5, 32'hFFFFFFFB); nv[1] = 1'b1;
        nb[96*2 +: 96] = v3(6, 5, 5);            nv[2] = 1'b1;
        send(v3(5, 5, 5), nb, nv, 14'h3FF9, t0);
        in_valid = 1'b0;
        wait_idle();

        // Extreme coordinates must not wrap into a small r2
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(32'h80000000, 0, 0); nv[0] = 1'b1;
        nb[96*1 +: 96] = v3(32'h7FFFFFF5, 0, 0); nv[1] = 1'b1;
        send(v3(32'h7FFFFFFF, 0, 0), nb, nv, 14'h3FFD, t0);
        in_valid = 1'b0;
        wait_idle();

        // Four back-to-back bundles with in_valid held high
        nb = '0; nv = '0;
        nb[96*13 +: 96] = v3(0, 0, 9); nv[13] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h1FFF, t0);
        nb = '0; nv = '0;
        nb[96*5 +: 96] = v3(1, 1, 1); nv[5] = 1'b1;
        nb[96*6 +: 96] = v3(0, 0, 0); nv[6] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h3FDF, t1);
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(0, 32'hFFFFFFF9, 32'hFFFFFFF9); nv[0] = 1'b1;
        nb[96*1 +: 96] = v3(0, 32'hFFFFFFF8, 32'hFFFFFFF9); nv[1] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h3FFE, t2);
        nb = '0; nv = 14'h3FFF;
        for (int i = 0; i < NSIZE; i++) nb[96*i +: 96] = v3(32'(i + 1), 0, 0);
        send(v3(0, 0, 0), nb, nv, 14'h3C00, t3);
        in_valid = 1'b0;
        check_val("accept_spacing_1", 64'(t1 - t0), 64'd160);
        check_val("accept_spacing_2", 64'(t2 - t1), 64'd160);
        check_val("accept_spacing_3", 64'(t3 - t2), 64'd160);
        wait_idle();

        // Reset in the middle of HOLD
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(3, 4, 0); nv[0] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h3FFE, t0);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (frame_start) break;
            @(negedge clk);
        end
        repeat (7) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_bundle("midhold_reset_out", out_bus, all_inv);
        check_val("midhold_reset_busy", 64'(busy), 64'd0);
        check_val("midhold_reset_frame_start", 64'(frame_start), 64'd0);
        check_val("midhold_reset_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        nb = '0; nv = '0;
        nb[96*0 +: 96] = v3(3, 4, 0);  nv[0] = 1'b1;
        nb[96*1 +: 96] = v3(10, 0, 0); nv[1] = 1'b1;
        nb[96*2 +: 96] = v3(10, 0, 1); nv[2] = 1'b1;
        send(v3(0, 0, 0), nb, nv, 14'h3FFC, t0);
        in_valid = 1'b0;
        wait_idle();

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
